// File: rtl/dmem_pkg.sv
// Shared types and big-endian lane helpers for the data-memory arbiter.
// Byte offset k sits in bits [31-8k -: 8]; half offset 0 is [31:16], offset 2 is [15:0].
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    localparam int MEM_BYTES_DEF = 1024;

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input size_e size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> (8 * (3 - int'(off))));
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_B:    r = {{24{b[7] & ~uns}}, b};
            SZ_H:    r = {{16{h[15] & ~uns}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] off,
                                               input size_e size, input logic [31:0] data);
        int          sh;
        logic [31:0] mask;
        logic [31:0] ins;
        case (size)
            SZ_B: begin
                sh   = 8 * (3 - int'(off));
                mask = 32'h0000_00FF << sh;
                ins  = {24'b0, data[7:0]} << sh;
            end
            SZ_H: begin
                sh   = off[1] ? 0 : 16;
                mask = 32'h0000_FFFF << sh;
                ins  = {16'b0, data[15:0]} << sh;
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                ins  = data;
            end
        endcase
        return (word & ~mask) | ins;
    endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Combinational lane extract (with sign/zero extension) and lane merge for RMW stores.
module dmem_lane_merge
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  size_e       size_i,
    input  logic        uns_i,
    input  logic [31:0] data_i,
    output logic [31:0] ext_o,
    output logic [31:0] merged_o
);

    assign ext_o    = lane_extract(word_i, off_i, size_i, uns_i);
    assign merged_o = lane_merge(word_i, off_i, size_i, data_i);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-requester arbiter and access sequencer for a word-write, big-endian
// data memory; sub-word stores become read-modify-write.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [1:0]             m_req_i,
    input  logic [1:0]             m_we_i,
    input  logic [1:0][1:0]        m_size_i,
    input  logic [1:0]             m_uns_i,
    input  logic [1:0][ADDR_W-1:0] m_addr_i,
    input  logic [1:0][31:0]       m_wdata_i,
    output logic [1:0]             m_gnt_o,
    output logic [1:0]             m_rvalid_o,
    output logic                   m_err_o,
    output logic [31:0]            m_rdata_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [31:0]            mem_wd_o,
    output logic                   mem_we_o,
    input  logic [31:0]            mem_rd_i
);

    state_e              state_q;
    logic                prio_q;
    logic                id_q;
    logic                we_q;
    logic                uns_q;
    logic                err_q;
    size_e               size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         data_q;

    logic [1:0]          gnt;
    logic                sel;
    logic                acc;
    logic                acc_err;
    size_e               acc_size;
    logic [ADDR_W-1:0]   acc_addr;
    logic [31:0]         lane_ext;
    logic [31:0]         lane_mrg;

    // Grant is gated by reset so every output reads zero while rst_ni is low.
    always_comb begin
        gnt = '0;
        if (rst_ni && state_q == ST_IDLE) begin
            if (m_req_i == 2'b11) begin
                gnt[prio_q] = 1'b1;
            end else begin
                gnt = m_req_i;
            end
        end
    end

    assign sel      = gnt[1];
    assign acc      = |(m_req_i & gnt);
    assign acc_size = size_e'(m_size_i[sel]);
    assign acc_addr = m_addr_i[sel];

    always_comb begin
        acc_err = 1'b0;
        case (acc_size)
            SZ_ILL:  acc_err = 1'b1;
            SZ_H:    acc_err = acc_addr[0];
            SZ_W:    acc_err = |acc_addr[1:0];
            default: acc_err = 1'b0;
        endcase
        if (acc_addr >= ADDR_W'(MEM_BYTES)) begin
            acc_err = 1'b1;
        end
    end

    dmem_lane_merge u_lane (
        .word_i   (mem_rd_i),
        .off_i    (addr_q[1:0]),
        .size_i   (size_q),
        .uns_i    (uns_q),
        .data_i   (data_q),
        .ext_o    (lane_ext),
        .merged_o (lane_mrg)
    );

    // data_q carries store data after acceptance, then the load result or merged word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc) begin
                        id_q   <= sel;
                        we_q   <= m_we_i[sel];
                        size_q <= acc_size;
                        uns_q  <= m_uns_i[sel];
                        addr_q <= acc_addr;
                        if (m_req_i == 2'b11) begin
                            prio_q <= ~sel;
                        end
                        if (acc_err) begin
                            err_q   <= 1'b1;
                            data_q  <= '0;
                            state_q <= ST_RESP;
                        end else begin
                            err_q   <= 1'b0;
                            data_q  <= m_wdata_i[sel];
                            state_q <= (m_we_i[sel] && acc_size == SZ_W) ? ST_WRITE : ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    data_q  <= we_q ? lane_mrg : lane_ext;
                    state_q <= we_q ? ST_WRITE : ST_RESP;
                end
                ST_WRITE: begin
                    data_q  <= '0;
                    state_q <= ST_RESP;
                end
                default: begin
                    err_q   <= 1'b0;
                    data_q  <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_gnt_o    = gnt;
    assign m_rvalid_o = (state_q == ST_RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign m_err_o    = (state_q == ST_RESP) && err_q;
    assign m_rdata_o  = (state_q == ST_RESP) ? data_q : 32'h0;
    assign mem_addr_o = (state_q == ST_READ || state_q == ST_WRITE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_we_o   = (state_q == ST_WRITE);
    assign mem_wd_o   = (state_q == ST_WRITE) ? data_q : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural word memory and hand-computed expectations.
module tb_dmem_arbiter;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        m_req = '0;
    logic [1:0]        m_we = '0;
    logic [1:0][1:0]   m_size = '0;
    logic [1:0]        m_uns = '0;
    logic [1:0][31:0]  m_addr = '0;
    logic [1:0][31:0]  m_wdata = '0;
    logic [1:0]        m_gnt;
    logic [1:0]        m_rvalid;
    logic              m_err;
    logic [31:0]       m_rdata;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wd;
    logic              mem_we;
    logic [31:0]       mem_rd;

    logic [31:0]       mem [0:255];
    int                we_cnt = 0;
    logic [31:0]       last_wa = '0;
    logic [31:0]       last_wd = '0;
    int                vecs = 0;
    int                errs = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .m_req_i    (m_req),
        .m_we_i     (m_we),
        .m_size_i   (m_size),
        .m_uns_i    (m_uns),
        .m_addr_i   (m_addr),
        .m_wdata_i  (m_wdata),
        .m_gnt_o    (m_gnt),
        .m_rvalid_o (m_rvalid),
        .m_err_o    (m_err),
        .m_rdata_o  (m_rdata),
        .mem_addr_o (mem_addr),
        .mem_wd_o   (mem_wd),
        .mem_we_o   (mem_we),
        .mem_rd_i   (mem_rd)
    );

    assign mem_rd = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[9:2]] = mem_wd;
            we_cnt  = we_cnt + 1;
            last_wa = mem_addr;
            last_wd = mem_wd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
        m_we[id]    = we;
        m_size[id]  = sz;
        m_uns[id]   = uns;
        m_addr[id]  = addr;
        m_wdata[id] = wd;
        m_req[id]   = 1'b1;
    endtask

    // Returns at the falling edge of the grant cycle.
    task automatic wait_gnt(input string tag, input logic [1:0] exp);
        int n = 0;
        #1;
        while (m_gnt == 2'b00 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, ".gnt"}, {30'b0, m_gnt}, {30'b0, exp});
    endtask

    task automatic wait_resp(input string tag, input logic [1:0] ev, input logic [31:0] erd,
                             input logic eerr, input int elat);
        bit got = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (m_rvalid != 2'b00) begin
                got = 1'b1;
                chk({tag, ".lat"}, c, elat);
                chk({tag, ".own"}, {30'b0, m_rvalid}, {30'b0, ev});
                chk({tag, ".rdata"}, m_rdata, erd);
                chk({tag, ".err"}, {31'b0, m_err}, {31'b0, eerr});
                $display("%-12s rvalid=%b lat=%0d rdata=0x%08h err=%b", tag, m_rvalid, c, m_rdata, m_err);
            end
        end
        if (!got) chk({tag, ".timeout"}, 32'd0, 32'd1);
    endtask

    task automatic access(input string tag, input int id, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] erd, input logic eerr, input int elat);
        @(negedge clk);
        set_req(id, we, sz, uns, addr, wd);
        wait_gnt(tag, (id == 1) ? 2'b10 : 2'b01);
        @(posedge clk);
        #1 m_req[id] = 1'b0;
        wait_resp(tag, (id == 1) ? 2'b10 : 2'b01, erd, eerr, elat);
    endtask

    initial begin
        int w0;
        int quiet;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        #12;
        chk("rst.gnt", {30'b0, m_gnt}, 32'h0);
        chk("rst.rvalid", {30'b0, m_rvalid}, 32'h0);
        chk("rst.we", {31'b0, mem_we}, 32'h0);
        chk("rst.addr", mem_addr, 32'h0);
        chk("rst.rdata", m_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        w0 = we_cnt;
        access("st_w", 0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        chk("st_w.wcnt", we_cnt - w0, 32'd1);
        chk("st_w.waddr", last_wa, 32'h10);
        chk("st_w.wdata", last_wd, 32'hDEADBEEF);
        access("ld_w", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        mem[4] = 32'h11223344;
        w0 = we_cnt;
        access("st_b", 0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 32'h0, 1'b0, 3);
        chk("st_b.wcnt", we_cnt - w0, 32'd1);
        chk("st_b.waddr", last_wa, 32'h10);
        chk("st_b.wdata", last_wd, 32'h11AA3344);
        access("ld_bs", 0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2);
        access("ld_bu", 0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2);
        access("ld_bu3", 1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000044, 1'b0, 2);

        mem[8] = 32'h80017FFE;
        access("ld_hs0", 1, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 32'hFFFF8001, 1'b0, 2);
        access("ld_hs2", 1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h00007FFE, 1'b0, 2);
        access("ld_hu0", 1, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h00008001, 1'b0, 2);
        w0 = we_cnt;
        access("st_h", 1, 1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF5678, 32'h0, 1'b0, 3);
        chk("st_h.wcnt", we_cnt - w0, 32'd1);
        chk("st_h.wdata", last_wd, 32'h80015678);

        w0 = we_cnt;
        access("err_wal", 0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1);
        access("err_hal", 1, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1, 1);
        access("err_sz", 0, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1);
        access("err_oor", 0, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1);
        access("err_stb", 1, 1'b1, 2'b00, 1'b0, 32'h400, 32'h55, 32'h0, 1'b1, 1);
        chk("err.wcnt", we_cnt - w0, 32'd0);

        // Both requesting continuously: grants must alternate starting at requester 0.
        @(negedge clk);
        set_req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wait_gnt($sformatf("cont%0d", k), (k % 2 == 1) ? 2'b10 : 2'b01);
            @(posedge clk);
            #1;
            wait_resp($sformatf("cont%0d", k), (k % 2 == 1) ? 2'b10 : 2'b01,
                      (k % 2 == 1) ? 32'h80015678 : 32'h11AA3344, 1'b0, 2);
        end
        m_req = 2'b00;

        // One contended grant to requester 0 leaves priority with requester 1.
        @(negedge clk);
        set_req(0, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
        set_req(1, 1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
        wait_gnt("prio", 2'b01);
        @(posedge clk);
        #1 m_req = 2'b00;
        wait_resp("prio", 2'b01, 32'h00000011, 1'b0, 2);

        mem[12] = 32'hCAFEF00D;
        w0 = we_cnt;
        @(negedge clk);
        set_req(0, 1'b1, 2'b00, 1'b0, 32'h31, 32'h55);
        wait_gnt("rstrmw", 2'b01);
        @(posedge clk);
        #1 m_req[0] = 1'b0;
        @(negedge clk);
        chk("rstrmw.raddr", mem_addr, 32'h30);
        rst_n = 1'b0;
        #1;
        chk("rstrmw.we", {31'b0, mem_we}, 32'h0);
        chk("rstrmw.addr", mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (m_rvalid != 2'b00) quiet++;
        end
        chk("rstrmw.norv", quiet, 32'd0);
        chk("rstrmw.wcnt", we_cnt - w0, 32'd0);
        chk("rstrmw.mem", mem[12], 32'hCAFEF00D);
        $display("%-12s reset during READ, memory word 0x%08h", "rstrmw", mem[12]);

        set_req(0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
        set_req(1, 1'b0, 2'b01, 1'b1, 32'h32, 32'h0);
        wait_gnt("postrst0", 2'b01);
        @(posedge clk);
        #1 m_req[0] = 1'b0;
        wait_resp("postrst0", 2'b01, 32'hCAFEF00D, 1'b0, 2);
        wait_gnt("postrst1", 2'b10);
        @(posedge clk);
        #1 m_req[1] = 1'b0;
        wait_resp("postrst1", 2'b10, 32'h0000F00D, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and access sequencer in front of the byte-addressed, big-endian, word-write data memory. Requester 0 is the core load/store unit and requester 1 is a debug/DMA port. Accesses are granted round-robin, one at a time. Sub-word stores are turned into read-modify-write sequences because the memory only writes whole words. Sub-word loads are extracted and sign- or zero-extended.

Parameters:
MEM_BYTES, 1024, memory size in bytes; addresses >= MEM_BYTES return an error response
ADDR_W, 32, address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
m_req_i  in  2  per-requester request; held stable with its fields until granted
m_we_i  in  2  per-requester store (1) / load (0)
m_size_i  in  2x2  per-requester size: 00 byte, 01 half, 10 word, 11 illegal
m_uns_i  in  2  per-requester load zero-extend (1) / sign-extend (0)
m_addr_i  in  2xADDR_W  per-requester byte address
m_wdata_i  in  2x32  per-requester store data, right-aligned
m_gnt_o  out  2  grant, one-hot or zero, combinational
m_rvalid_o  out  2  one-cycle response pulse to the owning requester
m_err_o  out  1  error flag, qualified by m_rvalid_o
m_rdata_o  out  32  load result, qualified by m_rvalid_o; zero for stores and errors
mem_addr_o  out  ADDR_W  word-aligned address to memory
mem_wd_o  out  32  write word
mem_we_o  out  1  memory write enable
mem_rd_i  in  32  combinational read word at mem_addr_o

Behaviour:
- Reset (async, rst_ni low): state IDLE; all outputs 0; round-robin priority points to requester 0. Reset mid-sequence abandons the access with no write and no response.
- States: IDLE, READ, WRITE, RESP.
- IDLE: grants are issued only in this state. If exactly one request is present, grant it. If both are present, grant the priority holder, then move priority to the other requester. Acceptance is req&gnt. On acceptance, latch id, we, size, uns, addr and wdata.
- Error check at acceptance: size 11; half with addr[0]=1; word with addr[1:0]!=0; addr >= MEM_BYTES. On error, go to RESP with err=1 and make no memory access.
- Next state after acceptance: load -> READ; word store -> WRITE; byte/half store -> READ.
- mem_addr_o = {latched addr[ADDR_W-1:2], 2'b00} in READ and WRITE; 0 otherwise.
- Byte lanes are big-endian. Byte offset k occupies bits [31-8k -: 8]. Half offset 0 is [31:16]; half offset 2 is [15:0].
- READ: register mem_rd_i. A load extracts and extends the lane, then goes to RESP. A sub-word store merges wdata's low byte or half into that lane, then goes to WRITE.
- WRITE: mem_we_o=1 for exactly one cycle with mem_wd_o = wdata (word store) or the merged word; then go to RESP.
- RESP: m_rvalid_o[id]=1 for one cycle with rdata/err; then go to IDLE. A new grant is possible the cycle after RESP.
- Latency from acceptance cycle N: load rvalid at N+2; word store N+2; sub-word store N+3; error N+1.
- mem_we_o is never asserted outside WRITE. Only the owner sees rvalid.
- A request deasserted before its grant is ignored. The priority pointer is unchanged when a single requester is granted without contention.

Decomposition:
- Package dmem_pkg holds:
  - size_e enum (SZ_B, SZ_H, SZ_W, SZ_ILL)
  - state_e enum
  - constant MEM_BYTES_DEF
  - functions lane_extract(word, off, size, uns) and lane_merge(word, off, size, data)
- Natural sub-module: dmem_lane_merge, combinational extract/merge wrapping those functions, separately unit-testable.

Test Plan:
- Word store then load: r0 store word 0xDEADBEEF @0x10 -> mem_we_o at N+1 with addr 0x10; r0 load word @0x10 -> rvalid[0] at N+2, rdata 0xDEADBEEF.
- Byte RMW: mem[0x10]=0x11223344; r0 store byte 0xAA @0x11 -> one read, then write 0x11AA3344; signed load byte @0x11 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- Half lanes: mem[0x20]=0x8001_7FFE; signed load half @0x20 -> 0xFFFF8001; @0x22 -> 0x00007FFE.
- Contention: both requesting continuously for 4 accesses -> grants alternate 0,1,0,1; each rvalid goes only to its owner.
- Errors: word load @0x12, half @0x21, size 11, load @0x400 -> rvalid at N+1, err=1, rdata 0, mem_we_o never asserted.
- Reset mid-RMW: deassert rst_ni during READ of a byte store -> mem_we_o stays 0, no rvalid, memory unchanged; priority back to requester 0.
